// File: rtl/xnort_parity_n.sv
`default_nettype none
// ============================================================================
//  Module      : xnort_parity_n
//  Description : N-channel toggle-coded XNOR-T / XOR-T parity element.
//                Each level change on din[i] marks channel i as arrived for
//                the current period. A level change on ev evaluates the
//                period: q toggles when (XOR of arrival flags) XOR INVERT = 1.
//                All pulses are masked for INIT_CYC cycles after reset.
//  Options     : `define XNORT_VIOLATION_CHK_EN adds the viol / viol_sticky
//                outputs. They flag any pulse that arrives within HOLD_CYC
//                cycles of an accepted evaluate.
//  Revision    : 1.0 - initial release
// ============================================================================
module xnort_parity_n #(
    parameter int N        = 2,
    parameter int INVERT   = 1,
    parameter int INIT_CYC = 8,
    parameter int HOLD_CYC = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         ev,
    output logic         q,
    output logic         ready,
    output logic [N-1:0] pend
`ifdef XNORT_VIOLATION_CHK_EN
    ,
    output logic         viol,
    output logic         viol_sticky
`endif
);

    localparam logic [7:0] INIT_LIM = 8'(INIT_CYC);
    localparam logic       INV_BIT  = (INVERT != 0);

    logic [N-1:0] din_s;
    logic [N-1:0] din_d;
    logic         ev_s;
    logic         ev_d;
    logic [7:0]   init_cnt;
    logic [N-1:0] din_pulse;
    logic [N-1:0] din_acc;
    logic         ev_acc;
    logic         q_flip;
    logic [N-1:0] pend_nxt;

    // Sample inputs once and keep the previous sample for edge detection.
    // These keep tracking during the init mask so that no stale level
    // difference turns into a pulse when the mask expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_s <= '0;
            din_d <= '0;
            ev_s  <= 1'b0;
            ev_d  <= 1'b0;
        end else begin
            din_s <= din;
            din_d <= din_s;
            ev_s  <= ev;
            ev_d  <= ev_s;
        end
    end

    // Saturating post-reset counter; ready is high once it reaches INIT_CYC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt <= 8'd0;
        end else if (init_cnt != INIT_LIM) begin
            init_cnt <= init_cnt + 8'd1;
        end
    end

    assign ready     = (init_cnt == INIT_LIM);
    assign din_pulse = din_s ^ din_d;
    assign din_acc   = din_pulse & {N{ready}};
    assign ev_acc    = (ev_s ^ ev_d) & ready;

    // Per-channel flag update. An evaluate consumes the current flags and a
    // pulse seen in the same cycle opens the next period instead.
    for (genvar i = 0; i < N; i++) begin : g_chan
        assign pend_nxt[i] = ev_acc ? din_acc[i] : (pend[i] | din_acc[i]);
    end

    // Arrival flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign q_flip = ev_acc & ((^pend) ^ INV_BIT);

    // Toggle-coded result: one level change per produced output pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (q_flip) begin
            q <= ~q;
        end
    end

`ifdef XNORT_VIOLATION_CHK_EN
    localparam logic [3:0] HOLD_LIM = 4'(HOLD_CYC);

    logic [3:0] win_cnt;
    logic       any_pulse;
    logic       viol_hit;

    // A pulse in the evaluate cycle itself, or while the window counter is
    // still running, lands inside the critical window.
    assign any_pulse = (|din_acc) | ev_acc;
    assign viol_hit  = (ev_acc & (|din_acc)) | ((win_cnt != 4'd0) & any_pulse);

    // Window counter plus one-cycle violation pulse and sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt     <= 4'd0;
            viol        <= 1'b0;
            viol_sticky <= 1'b0;
        end else begin
            if (ev_acc) begin
                win_cnt <= HOLD_LIM;
            end else if (win_cnt != 4'd0) begin
                win_cnt <= win_cnt - 4'd1;
            end
            viol        <= viol_hit;
            viol_sticky <= viol_sticky | viol_hit;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_xnort_parity_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_xnort_parity_n
//  Description : Self-checking bench for xnort_parity_n. Three instances
//                (N=2/XNOR, N=4/XOR, N=4/XNOR) share clk, rst, ev and din.
//                A set/parity reference model predicts q, pend and viol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xnort_parity_n;

    localparam int INIT = 8;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'h0;
    logic       ev  = 1'b0;

    logic       q2, rdy2, q4x, rdy4x, q4n, rdy4n;
    logic [1:0] pend2;
    logic [3:0] pend4x, pend4n;
`ifdef XNORT_VIOLATION_CHK_EN
    logic       v2, s2, v4x, s4x, v4n, s4n;
`endif

    always #5 clk = ~clk;

    xnort_parity_n #(.N(2), .INVERT(1), .INIT_CYC(INIT), .HOLD_CYC(HOLD)) u2 (
        .clk(clk), .rst(rst), .din(din[1:0]), .ev(ev),
        .q(q2), .ready(rdy2), .pend(pend2)
`ifdef XNORT_VIOLATION_CHK_EN
        , .viol(v2), .viol_sticky(s2)
`endif
    );

    xnort_parity_n #(.N(4), .INVERT(0), .INIT_CYC(INIT), .HOLD_CYC(HOLD)) u4x (
        .clk(clk), .rst(rst), .din(din), .ev(ev),
        .q(q4x), .ready(rdy4x), .pend(pend4x)
`ifdef XNORT_VIOLATION_CHK_EN
        , .viol(v4x), .viol_sticky(s4x)
`endif
    );

    xnort_parity_n #(.N(4), .INVERT(1), .INIT_CYC(INIT), .HOLD_CYC(HOLD)) u4n (
        .clk(clk), .rst(rst), .din(din), .ev(ev),
        .q(q4n), .ready(rdy4n), .pend(pend4n)
`ifdef XNORT_VIOLATION_CHK_EN
        , .viol(v4n), .viol_sticky(s4n)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // Instance k: 0 = u2, 1 = u4x, 2 = u4n.
    int       edge_no;
    bit [3:0] cur_mask, rec_mask;
    bit       cur_ev, rec_ev, rec_vld;
    int       rec_edge;
    int       last_ev;
    bit       m_q[3];
    bit [3:0] m_arr[3];
    bit       m_viol[3];
    bit       m_stk[3];

    function automatic bit [3:0] wid(int k);
        return (k == 0) ? 4'h3 : 4'hF;
    endfunction

    function automatic bit inv(int k);
        return (k != 1);
    endfunction

    task automatic model_clear();
        edge_no  = 0;
        cur_mask = 4'h0;
        cur_ev   = 1'b0;
        rec_vld  = 1'b0;
        last_ev  = -1000;
        for (int k = 0; k < 3; k++) begin
            m_q[k] = 1'b0; m_arr[k] = 4'h0; m_viol[k] = 1'b0; m_stk[k] = 1'b0;
        end
    endtask

    // Effect of one period's worth of pulses becoming visible at edge e.
    task automatic model_apply(int e, bit [3:0] msk, bit evt);
        bit [3:0] dm;
        bit       hit;
        for (int k = 0; k < 3; k++) begin
            dm  = msk & wid(k);
            hit = 1'b0;
            if ((dm != 4'h0 || evt) && (e - last_ev >= 1) && (e - last_ev <= HOLD)) hit = 1'b1;
            if (evt && dm != 4'h0) hit = 1'b1;
            m_viol[k] = hit;
            if (hit) m_stk[k] = 1'b1;
            if (evt) begin
                if ((($countones(m_arr[k]) % 2) == 1) != inv(k)) m_q[k] = !m_q[k];
                m_arr[k] = dm;
            end else begin
                m_arr[k] = m_arr[k] | dm;
            end
        end
        if (evt) last_ev = e;
    endtask

    // Advance one clock; a pulse sampled at edge k takes effect at edge k+1
    // if the init mask has expired by then.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) m_viol[k] = 1'b0;
        if (rst) begin
            model_clear();
        end else begin
            edge_no++;
            if (rec_vld && rec_edge >= INIT) model_apply(edge_no, rec_mask, rec_ev);
            rec_vld  = 1'b1;
            rec_mask = cur_mask;
            rec_ev   = cur_ev;
            rec_edge = edge_no;
            cur_mask = 4'h0;
            cur_ev   = 1'b0;
        end
        #1;
    endtask

    task automatic drive(input bit [3:0] mask, input bit e);
        din      = din ^ mask;
        ev       = ev ^ e;
        cur_mask = mask;
        cur_ev   = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        din = 4'h0;
        ev  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (INIT) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        din = 4'hF;
        ev  = 1'b1;
        tick();
        tick();
        n_cmp++; if ({q2, q4x, q4n} !== 3'b000) begin n_bad++; $display("FAIL reset_q: got %b want 000", {q2, q4x, q4n}); end
        n_cmp++; if ({pend2, pend4x, pend4n} !== 10'h0) begin n_bad++; $display("FAIL reset_pend: got %h want 0", {pend2, pend4x, pend4n}); end
        n_cmp++; if ({rdy2, rdy4x, rdy4n} !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b want 000", {rdy2, rdy4x, rdy4n}); end
`ifdef XNORT_VIOLATION_CHK_EN
        n_cmp++; if ({v2, s2, v4x, s4x, v4n, s4n} !== 6'h0) begin n_bad++; $display("FAIL reset_viol: got %b want 0", {v2, s2, v4x, s4x, v4n, s4n}); end
`endif
    endtask

    // Inputs left high through reset plus toggles during the mask window.
    task automatic test_init_mask();
        rst = 1'b0;
        for (int i = 1; i < INIT; i++) begin
            drive(4'($urandom), 1'b1);
            tick();
            n_cmp++; if ({rdy2, rdy4x, rdy4n} !== 3'b000) begin n_bad++; $display("FAIL mask_ready_c%0d: got %b want 000", i, {rdy2, rdy4x, rdy4n}); end
            n_cmp++; if ({q2, q4x, q4n, pend2, pend4x, pend4n} !== 13'h0) begin n_bad++; $display("FAIL mask_state_c%0d: got %h want 0", i, {q2, q4x, q4n, pend2, pend4x, pend4n}); end
        end
        tick();
        n_cmp++; if ({rdy2, rdy4x, rdy4n} !== 3'b111) begin n_bad++; $display("FAIL mask_ready_c8: got %b want 111", {rdy2, rdy4x, rdy4n}); end
        tick();
        tick();
        n_cmp++; if ({q2, q4x, q4n, pend2, pend4x, pend4n} !== 13'h0) begin n_bad++; $display("FAIL mask_spurious: got %h want 0", {q2, q4x, q4n, pend2, pend4x, pend4n}); end
    endtask

    task automatic test_basic();
        do_reset();
        drive(4'h1, 1'b0); tick(); tick();
        n_cmp++; if (pend2 !== 2'b01) begin n_bad++; $display("FAIL basic_pend_d0: got %b want 01", pend2); end
        drive(4'h2, 1'b0); tick(); tick();
        n_cmp++; if (pend2 !== 2'b11 || q2 !== 1'b0) begin n_bad++; $display("FAIL basic_pend_d1: got pend=%b q=%b want pend=11 q=0", pend2, q2); end
        drive(4'h0, 1'b1); tick();
        n_cmp++; if (q2 !== 1'b0) begin n_bad++; $display("FAIL basic_latency: got q=%b want 0", q2); end
        tick();
        n_cmp++; if (q2 !== 1'b1 || pend2 !== 2'b00) begin n_bad++; $display("FAIL basic_eval: got q=%b pend=%b want q=1 pend=00", q2, pend2); end
    endtask

    task automatic test_double();
        do_reset();
        drive(4'h1, 1'b0); tick();
        drive(4'h1, 1'b0); tick(); tick();
        n_cmp++; if (pend2 !== 2'b01) begin n_bad++; $display("FAIL double_pend: got %b want 01", pend2); end
        drive(4'h0, 1'b1); tick(); tick();
        n_cmp++; if (q2 !== 1'b0 || pend2 !== 2'b00) begin n_bad++; $display("FAIL double_hold: got q=%b pend=%b want q=0 pend=00", q2, pend2); end
        drive(4'h0, 1'b1); tick(); tick();
        n_cmp++; if (q2 !== 1'b1) begin n_bad++; $display("FAIL double_empty: got q=%b want 1", q2); end
    endtask

    task automatic test_multi();
        do_reset();
        drive(4'h7, 1'b0); tick(); tick();
        n_cmp++; if (pend4x !== 4'b0111) begin n_bad++; $display("FAIL multi_pend: got %b want 0111", pend4x); end
        drive(4'h0, 1'b1); tick(); tick();
        n_cmp++; if (q4x !== 1'b1 || q4n !== 1'b0 || pend4x !== 4'h0) begin n_bad++; $display("FAIL multi_odd: got q4x=%b q4n=%b pend=%b want 1 0 0000", q4x, q4n, pend4x); end
        drive(4'h3, 1'b0); tick();
        drive(4'h0, 1'b1); tick(); tick();
        n_cmp++; if (q4x !== 1'b1 || q4n !== 1'b1) begin n_bad++; $display("FAIL multi_even: got q4x=%b q4n=%b want 1 1", q4x, q4n); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(4'h1, 1'b1); tick(); tick();
        n_cmp++; if (q4n !== 1'b1 || pend4n !== 4'b0001) begin n_bad++; $display("FAIL same_u4n: got q=%b pend=%b want q=1 pend=0001", q4n, pend4n); end
        n_cmp++; if (q2 !== 1'b1 || pend2 !== 2'b01 || q4x !== 1'b0) begin n_bad++; $display("FAIL same_other: got q2=%b pend2=%b q4x=%b want 1 01 0", q2, pend2, q4x); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(4'h1, 1'b0); tick(); tick();
        rst = 1'b1;
        #1;
        model_clear();
        n_cmp++; if ({q2, rdy2, pend2, rdy4x, pend4x} !== 9'h0) begin n_bad++; $display("FAIL midrst_async: got %h want 0", {q2, rdy2, pend2, rdy4x, pend4x}); end
        tick();
        rst = 1'b0;
        repeat (INIT) tick();
        drive(4'h0, 1'b1); tick(); tick();
        n_cmp++; if (q2 !== 1'b1 || pend2 !== 2'b00) begin n_bad++; $display("FAIL midrst_eval: got q=%b pend=%b want q=1 pend=00", q2, pend2); end
    endtask

`ifdef XNORT_VIOLATION_CHK_EN
    task automatic test_viol();
        do_reset();
        drive(4'h0, 1'b1); tick(); tick();
        drive(4'h2, 1'b0); tick();
        n_cmp++; if (v2 !== 1'b0) begin n_bad++; $display("FAIL viol_early: got %b want 0", v2); end
        tick();
        n_cmp++; if (v2 !== 1'b1 || s2 !== 1'b1) begin n_bad++; $display("FAIL viol_hit: got viol=%b sticky=%b want 1 1", v2, s2); end
        tick();
        n_cmp++; if (v2 !== 1'b0 || s2 !== 1'b1) begin n_bad++; $display("FAIL viol_pulse: got viol=%b sticky=%b want 0 1", v2, s2); end
        repeat (5) tick();
        n_cmp++; if (s2 !== 1'b1) begin n_bad++; $display("FAIL viol_sticky_hold: got %b want 1", s2); end
        do_reset();
        n_cmp++; if (s2 !== 1'b0) begin n_bad++; $display("FAIL viol_sticky_clr: got %b want 0", s2); end
        drive(4'h0, 1'b1); tick(); tick(); tick(); tick();
        drive(4'h2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (v2 !== 1'b0 || s2 !== 1'b0) begin n_bad++; $display("FAIL viol_outside_c%0d: got viol=%b sticky=%b want 0 0", i, v2, s2); end
        end
    endtask
`endif

    task automatic test_random();
        bit       gq[3];
        bit [3:0] gp[3];
        bit       gv[3];
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, ($urandom_range(0, 3) == 0));
            tick();
            gq = '{q2, q4x, q4n};
            gp = '{{2'b00, pend2}, pend4x, pend4n};
`ifdef XNORT_VIOLATION_CHK_EN
            gv = '{v2, v4x, v4n};
`else
            gv = '{1'b0, 1'b0, 1'b0};
`endif
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (gq[k] !== m_q[k]) begin n_bad++; $display("FAIL rand_q_i%0d_c%0d: got %b want %b", k, c, gq[k], m_q[k]); end
                n_cmp++; if (gp[k] !== m_arr[k]) begin n_bad++; $display("FAIL rand_pend_i%0d_c%0d: got %b want %b", k, c, gp[k], m_arr[k]); end
`ifdef XNORT_VIOLATION_CHK_EN
                n_cmp++; if (gv[k] !== m_viol[k]) begin n_bad++; $display("FAIL rand_viol_i%0d_c%0d: got %b want %b", k, c, gv[k], m_viol[k]); end
`endif
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_init_mask();
        test_basic();
        test_double();
        test_multi();
        test_same_cycle();
        test_mid_reset();
`ifdef XNORT_VIOLATION_CHK_EN
        test_viol();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xnort_parity_n.md
XNORT_PARITY_N -- requirements
Module: xnort_parity_n

Interface
REQ-001 SHALL have parameter N, default 2: number of data channels, legal range 2..16.
REQ-002 SHALL have parameter INVERT, default 1: 1 selects XNOR-T, 0 selects XOR-T.
REQ-003 SHALL have parameter INIT_CYC, default 8: event-mask cycles after reset release, legal range 1..255.
REQ-004 SHALL have parameter HOLD_CYC, default 3: critical window in cycles after an evaluate event, legal range 1..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port din, input, N bits: toggle-coded data pulses, any level change on bit i = one pulse on channel i.
REQ-008 SHALL have port ev, input, 1 bit: toggle-coded evaluate pulse.
REQ-009 SHALL have port q, output, 1 bit: toggle-coded result, one level change = one output pulse.
REQ-010 SHALL have port ready, output, 1 bit: high once the INIT_CYC mask has expired.
REQ-011 SHALL have port pend, output, N bits: current per-channel arrival flags.

Function
REQ-012 SHALL register din and ev once (sampled) and detect a pulse as sampled value XOR previous sampled value.
REQ-013 SHALL set pend[i] on a detected pulse on channel i; a second pulse on an already-set channel within the same period SHALL be ignored.
REQ-014 SHALL, on a detected ev pulse, toggle q when (XOR of pend) XOR INVERT equals 1; otherwise q SHALL hold.
REQ-015 SHALL clear all pend bits on the same edge that evaluates ev.
REQ-016 SHALL give q a latency of exactly 1 cycle from the edge that samples the ev change to the edge that updates q.
REQ-017 SHALL treat an ev pulse and channel-i pulse detected in the same cycle as evaluate-first: pend excludes i for this evaluation, and pend[i] is set for the next period.
REQ-018 SHALL ignore all din and ev pulses while ready is low; sampled registers keep tracking inputs so no spurious pulse appears at mask expiry.
REQ-019 SHALL count INIT_CYC cycles from reset deassertion with a saturating counter and raise ready on reaching INIT_CYC.
REQ-020 SHALL give all N channels identical, order-independent behaviour; pulses on multiple channels in one cycle SHALL all be captured.

Reset
REQ-021 SHALL, while rst is high, force q=0, pend=0, ready=0, init counter=0, sampled registers=0, window counter idle, and any violation state=0.
REQ-022 SHALL abandon an in-progress period on rst assertion mid-operation, with no q toggle from flags captured before reset.

Configuration
REQ-023 SHALL, with XNORT_VIOLATION_CHK_EN defined, add output viol (1 bit) and output viol_sticky (1 bit).
REQ-024 SHALL, with XNORT_VIOLATION_CHK_EN defined, pulse viol high for 1 cycle for any din or ev pulse detected from 0 to HOLD_CYC cycles (inclusive) after an accepted ev pulse.
REQ-025 SHALL, with XNORT_VIOLATION_CHK_EN defined, set viol_sticky on any viol pulse and clear it only by rst; violating pulses are still processed per REQ-013..017.
REQ-026 SHALL, without XNORT_VIOLATION_CHK_EN defined, omit viol, viol_sticky and the window counter, with functional behaviour otherwise identical.

Verification
REQ-027 SHALL cover: N=2, INVERT=1, ready high, din[0] toggles, then din[1] toggles, then ev toggles -> pend=2'b11 before ev, q toggles 0->1 one cycle after ev sampled, pend=0.
REQ-028 SHALL cover: N=2, INVERT=1, din[0] toggles twice, then ev -> pend=2'b01, q unchanged; the next ev with no pulses -> q toggles.
REQ-029 SHALL cover: N=4, INVERT=0, pulses on channels 0,1,2 in one cycle, then ev -> q toggles; repeat with channels 0,1 only -> q holds.
REQ-030 SHALL cover: din[0] and ev toggle in the same cycle, INVERT=1 -> q toggles (empty pend), pend=4'b0001 afterwards.
REQ-031 SHALL cover: din and ev toggling during the first 7 cycles after rst release -> q=0, pend=0, ready rises at cycle 8, no spurious pulse.
REQ-032 SHALL cover, with XNORT_VIOLATION_CHK_EN defined and HOLD_CYC=3: din[1] pulse 2 cycles after ev -> viol pulses once, viol_sticky=1 until rst; the same pulse at 4 cycles -> no viol.
